// File: rtl/urisc_core.sv
// SUBLEQ-style URISC core: mem[B] <= mem[B] - mem[A]; branch to C when the result is negative.
// Optional retired-instruction counter is enabled by defining URISC_INSTR_CNT_EN.
module urisc_core #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int START_PC  = 1,
    parameter int HALT_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          CS,
    output logic          READ,
    output logic          WRITE,
    output logic [AW-1:0] ADDRESS,
    output logic [DW-1:0] WDATA,
    input  logic [DW-1:0] RDATA,
    output logic          busy,
    output logic          halted,
    output logic [15:0]   instr_cnt,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FA   = 3'd1,
        S_FB   = 3'd2,
        S_FC   = 3'd3,
        S_RA   = 3'd4,
        S_RB   = 3'd5,
        S_WB   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam logic [AW-1:0] START_A = AW'(START_PC);
    localparam logic [AW-1:0] HALT_A  = AW'(HALT_ADDR);

    state_t        state;
    logic [AW-1:0] pc;
    logic [AW-1:0] a, b, c;
    logic [DW-1:0] opa;
    logic [DW-1:0] diff;
    logic [AW-1:0] next_pc;

    assign next_pc   = diff[DW-1] ? c : pc + AW'(3);
    assign state_dbg = state;

    // All bus outputs are registered: each transition loads the values the next state drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= START_A;
            a       <= '0;
            b       <= '0;
            c       <= '0;
            opa     <= '0;
            diff    <= '0;
            CS      <= 1'b0;
            READ    <= 1'b0;
            WRITE   <= 1'b0;
            ADDRESS <= '0;
            WDATA   <= '0;
            busy    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state   <= S_FA;
                        pc      <= START_A;
                        CS      <= 1'b1;
                        READ    <= 1'b1;
                        ADDRESS <= START_A;
                        busy    <= 1'b1;
                        halted  <= 1'b0;
                    end
                end
                S_FA: begin
                    a       <= AW'(RDATA);
                    ADDRESS <= pc + AW'(1);
                    state   <= S_FB;
                end
                S_FB: begin
                    b       <= AW'(RDATA);
                    ADDRESS <= pc + AW'(2);
                    state   <= S_FC;
                end
                S_FC: begin
                    c       <= AW'(RDATA);
                    ADDRESS <= a;
                    state   <= S_RA;
                end
                S_RA: begin
                    opa     <= RDATA;
                    ADDRESS <= b;
                    state   <= S_RB;
                end
                S_RB: begin
                    diff  <= RDATA - opa;
                    WDATA <= RDATA - opa;
                    READ  <= 1'b0;
                    WRITE <= 1'b1;
                    state <= S_WB;
                end
                S_WB: begin
                    pc    <= next_pc;
                    WRITE <= 1'b0;
                    WDATA <= '0;
                    if (next_pc == HALT_A) begin
                        state   <= S_HALT;
                        CS      <= 1'b0;
                        ADDRESS <= '0;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                    end else begin
                        state   <= S_FA;
                        READ    <= 1'b1;
                        ADDRESS <= next_pc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef URISC_INSTR_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if ((state == S_IDLE || state == S_HALT) && start) begin
            cnt_q <= '0;
        end else if (state == S_WB && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_urisc_core.sv
// Directed bench for urisc_core: behavioural combinational-read RAM plus hand-computed programs.
module tb_urisc_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cs, rd, wr;
  logic [7:0]  address, wdata, rdata;
  logic        busy, halted;
  logic [15:0] instr_cnt;
  logic [2:0]  state_dbg;

  logic [7:0]  mem [0:255];
  logic [7:0]  exp_q[$];
  logic [7:0]  addr_log[$];

  int checks = 0;
  int passed = 0;
  int cycles;

  urisc_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .CS        (cs),
    .READ      (rd),
    .WRITE     (wr),
    .ADDRESS   (address),
    .WDATA     (wdata),
    .RDATA     (rdata),
    .busy      (busy),
    .halted    (halted),
    .instr_cnt (instr_cnt),
    .state_dbg (state_dbg)
  );

  // clock / RAM
  always #5 clk = ~clk;

  assign rdata = mem[address];

  always @(posedge clk) begin
    if (cs && wr) mem[address] <= wdata;
  end

  // driver tasks
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulses start, then logs ADDRESS every busy cycle until the core drops busy.
  task automatic run_prog(input int max_cycles, input int poke_every, output int n);
    addr_log.delete();
    n = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy && n < max_cycles) begin
      addr_log.push_back(address);
      checks++;
      if ((rd && wr) !== 1'b0) $display("FAIL rw_exclusive cycle %0d: READ=%b WRITE=%b, required not both", n, rd, wr);
      else passed++;
      start = (poke_every != 0 && (n % poke_every) == 3);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL run_timeout: busy=%b after %0d cycles, required 0", busy, n);
    else passed++;
  endtask

  // scoreboard: compare the logged address trace against exp_q
  task automatic check_trace(input string name);
    int bad;
    bad = -1;
    if (addr_log.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (bad < 0 && addr_log[i] !== exp_q[i]) bad = i;
      end
    end else begin
      bad = 0;
    end
    checks++;
    if (bad >= 0)
      $display("FAIL %s: trace len %0d first bad idx %0d, required len %0d", name, addr_log.size(), bad, exp_q.size());
    else passed++;
  endtask

  task automatic load_t2();
    clear_mem();
    mem[1] = 8'd10; mem[2] = 8'd11; mem[3] = 8'd0;
    mem[10] = 8'd5; mem[11] = 8'd3;
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    checks++;
    if ({cs, rd, wr, busy, halted, address, wdata, instr_cnt, state_dbg} !== 45'd0)
      $display("FAIL reset_outputs: cs=%b rd=%b wr=%b busy=%b halted=%b addr=%0d wdata=%0d cnt=%0d st=%0d, required all 0",
               cs, rd, wr, busy, halted, address, wdata, instr_cnt, state_dbg);
    else passed++;
  endtask

  task automatic test_single();
    load_t2();
    run_prog(100, 0, cycles);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd10, 8'd11, 8'd11};
    check_trace("single_trace");
    checks++;
    if (cycles !== 6) $display("FAIL single_cycles: got %0d, required 6", cycles); else passed++;
    checks++;
    if (mem[11] !== 8'hFE) $display("FAIL single_result: mem[11]=%h, required fe", mem[11]); else passed++;
    checks++;
    if (mem[10] !== 8'd5) $display("FAIL single_src_kept: mem[10]=%h, required 05", mem[10]); else passed++;
    checks++;
    if ({halted, busy, cs, state_dbg} !== {1'b1, 1'b0, 1'b0, 3'd7})
      $display("FAIL single_halt: halted=%b busy=%b cs=%b st=%0d, required 1 0 0 7", halted, busy, cs, state_dbg);
    else passed++;
    checks++;
`ifdef URISC_INSTR_CNT_EN
    if (instr_cnt !== 16'd1) $display("FAIL single_cnt: got %0d, required 1", instr_cnt); else passed++;
`else
    if (instr_cnt !== 16'd0) $display("FAIL single_cnt: got %0d, required 0", instr_cnt); else passed++;
`endif
  endtask

  task automatic test_zero_no_branch();
    do_reset();
    clear_mem();
    mem[1] = 8'd10; mem[2] = 8'd10; mem[3] = 8'd50;
    mem[4] = 8'd20; mem[5] = 8'd21; mem[6] = 8'd0;
    mem[10] = 8'd7; mem[20] = 8'd1; mem[21] = 8'd0;
    run_prog(100, 0, cycles);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd10, 8'd10, 8'd10, 8'd4, 8'd5, 8'd6, 8'd20, 8'd21, 8'd21};
    check_trace("zero_trace");
    checks++;
    if (mem[10] !== 8'h00) $display("FAIL zero_result: mem[10]=%h, required 00", mem[10]); else passed++;
    checks++;
    if (mem[21] !== 8'hFF) $display("FAIL zero_second: mem[21]=%h, required ff", mem[21]); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    clear_mem();
    mem[1] = 8'd20; mem[2] = 8'd21; mem[3] = 8'd253;
    mem[20] = 8'd1; mem[21] = 8'd0;
    mem[253] = 8'd10; mem[254] = 8'd11; mem[255] = 8'd40;
    mem[10] = 8'd1; mem[11] = 8'd9;
    run_prog(100, 0, cycles);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd20, 8'd21, 8'd21, 8'd253, 8'd254, 8'd255, 8'd10, 8'd11, 8'd11};
    check_trace("wrap_trace");
    checks++;
    if (mem[11] !== 8'd8) $display("FAIL wrap_result: mem[11]=%h, required 08", mem[11]); else passed++;
    checks++;
    if (halted !== 1'b1) $display("FAIL wrap_halt: halted=%b, required 1", halted); else passed++;
  endtask

  task automatic load_loop();
    clear_mem();
    mem[1] = 8'd30; mem[2] = 8'd31; mem[3] = 8'd1;
    mem[4] = 8'd33; mem[5] = 8'd34; mem[6] = 8'd0;
    mem[30] = 8'hFF; mem[31] = 8'hFB;
    mem[33] = 8'd1;  mem[34] = 8'd0;
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
      exp_q.push_back(8'd30); exp_q.push_back(8'd31); exp_q.push_back(8'd31);
    end
    exp_q.push_back(8'd4); exp_q.push_back(8'd5); exp_q.push_back(8'd6);
    exp_q.push_back(8'd33); exp_q.push_back(8'd34); exp_q.push_back(8'd34);
  endtask

  task automatic test_loop();
    do_reset();
    load_loop();
    run_prog(500, 0, cycles);
    check_trace("loop_trace");
    checks++;
    if (cycles !== 36) $display("FAIL loop_cycles: got %0d, required 36", cycles); else passed++;
    checks++;
    if ({mem[31], mem[34]} !== {8'h00, 8'hFF})
      $display("FAIL loop_result: mem[31]=%h mem[34]=%h, required 00 ff", mem[31], mem[34]);
    else passed++;
    checks++;
`ifdef URISC_INSTR_CNT_EN
    if (instr_cnt !== 16'd6) $display("FAIL loop_cnt: got %0d, required 6", instr_cnt); else passed++;
`else
    if (instr_cnt !== 16'd0) $display("FAIL loop_cnt: got %0d, required 0", instr_cnt); else passed++;
`endif
    // restart from HALT on the modified memory: 0-(-1)=1 falls through, then 0xFF-1 branches to 0
    run_prog(500, 0, cycles);
    checks++;
    if (cycles !== 12) $display("FAIL restart_cycles: got %0d, required 12", cycles); else passed++;
    checks++;
    if ({mem[31], mem[34]} !== {8'h01, 8'hFE})
      $display("FAIL restart_result: mem[31]=%h mem[34]=%h, required 01 fe", mem[31], mem[34]);
    else passed++;
    checks++;
`ifdef URISC_INSTR_CNT_EN
    if (instr_cnt !== 16'd2) $display("FAIL restart_cnt: got %0d, required 2", instr_cnt); else passed++;
`else
    if (instr_cnt !== 16'd0) $display("FAIL restart_cnt: got %0d, required 0", instr_cnt); else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_loop();
    run_prog(500, 5, cycles);
    check_trace("busy_start_trace");
    checks++;
    if (cycles !== 36) $display("FAIL busy_start_cycles: got %0d, required 36", cycles); else passed++;
    checks++;
    if ({mem[31], mem[34]} !== {8'h00, 8'hFF})
      $display("FAIL busy_start_result: mem[31]=%h mem[34]=%h, required 00 ff", mem[31], mem[34]);
    else passed++;
  endtask

  task automatic test_reset_in_wb();
    do_reset();
    load_t2();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({wr, state_dbg} !== {1'b1, 3'd6}) $display("FAIL wb_reached: wr=%b st=%0d, required 1 6", wr, state_dbg);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cs, rd, wr, busy, halted, address, wdata, state_dbg} !== 29'd0)
      $display("FAIL wb_reset_outputs: cs=%b rd=%b wr=%b busy=%b halted=%b addr=%0d st=%0d, required all 0",
               cs, rd, wr, busy, halted, address, state_dbg);
    else passed++;
    @(negedge clk);
    checks++;
    if (mem[11] !== 8'd3) $display("FAIL wb_no_write: mem[11]=%h, required 03", mem[11]); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    run_prog(100, 0, cycles);
    checks++;
    if ({cycles[7:0], mem[11]} !== {8'd6, 8'hFE})
      $display("FAIL wb_rerun: cycles=%0d mem[11]=%h, required 6 fe", cycles, mem[11]);
    else passed++;
  endtask

  // sequence + final report
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear_mem();
    test_reset();
    test_single();
    test_zero_no_branch();
    test_wrap();
    test_loop();
    test_back_to_back();
    test_reset_in_wb();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
